// File: rtl/fp_add_normalizer_if.sv
// Handshake bundle between the FP add datapath, the normaliser and its consumer.
// master drives raw sums and consumes packed words; slave is the normaliser.
interface fp_add_normalizer_if #(
    parameter int EXP_W  = 8,
    parameter int FRAC_W = 23
);
    logic                    in_valid;
    logic                    in_ready;
    logic                    in_sign;
    logic [EXP_W-1:0]        in_exp;
    logic [FRAC_W:0]         in_mant;
    logic                    in_carry;
    logic                    out_valid;
    logic                    out_ready;
    logic [EXP_W+FRAC_W:0]   out_result;
    logic                    out_overflow;
    logic                    out_underflow;
    logic                    out_zero;

    modport master (
        output in_valid, in_sign, in_exp, in_mant, in_carry, out_ready,
        input  in_ready, out_valid, out_result,
        input  out_overflow, out_underflow, out_zero
    );

    modport slave (
        input  in_valid, in_sign, in_exp, in_mant, in_carry, out_ready,
        output in_ready, out_valid, out_result,
        output out_overflow, out_underflow, out_zero
    );
endinterface

// File: rtl/fp_add_normalizer.sv
// Iterative normalise/pack stage after the FP adder: one shift per cycle,
// truncating, emits packed single-precision word plus exclusive status flags.
module fp_add_normalizer #(
    parameter int EXP_W  = 8,
    parameter int FRAC_W = 23
) (
    input  logic                clk,
    input  logic                rst_n,
    fp_add_normalizer_if.slave  bus
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] NORM = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam logic [EXP_W-1:0] EXP_MAX = {EXP_W{1'b1}};
    localparam logic [EXP_W-1:0] EXP_ONE = {{(EXP_W-1){1'b0}}, 1'b1};

    logic [1:0]             state_q, state_d;
    logic                   sign_q, sign_d;
    logic [EXP_W-1:0]       exp_q, exp_d;
    logic [FRAC_W:0]        mant_q, mant_d;
    logic                   carry_q, carry_d;
    logic [EXP_W+FRAC_W:0]  res_q, res_d;
    logic                   vld_q, vld_d;
    logic                   ovf_q, ovf_d;
    logic                   unf_q, unf_d;
    logic                   zero_q, zero_d;
    logic [EXP_W-1:0]       exp_inc;

    assign exp_inc = exp_q + EXP_ONE;

    assign bus.in_ready      = (state_q == IDLE);
    assign bus.out_valid     = vld_q;
    assign bus.out_result    = res_q;
    assign bus.out_overflow  = ovf_q;
    assign bus.out_underflow = unf_q;
    assign bus.out_zero      = zero_q;

    // Next-state: accept in IDLE, one normalise action per NORM cycle, hold in DONE.
    always_comb begin
        state_d = state_q;
        sign_d  = sign_q;
        exp_d   = exp_q;
        mant_d  = mant_q;
        carry_d = carry_q;
        res_d   = res_q;
        vld_d   = vld_q;
        ovf_d   = ovf_q;
        unf_d   = unf_q;
        zero_d  = zero_q;
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    sign_d  = bus.in_sign;
                    mant_d  = bus.in_mant;
                    carry_d = bus.in_carry;
                    exp_d   = (bus.in_exp == '0) ? EXP_ONE : bus.in_exp;
                    if (bus.in_exp == EXP_MAX) begin
                        res_d   = {bus.in_sign, EXP_MAX, bus.in_mant[FRAC_W-1:0]};
                        vld_d   = 1'b1;
                        state_d = DONE;
                    end else begin
                        state_d = NORM;
                    end
                end
            end
            NORM: begin
                if (carry_q) begin
                    mant_d  = {1'b1, mant_q[FRAC_W:1]};
                    exp_d   = exp_inc;
                    carry_d = 1'b0;
                    if (exp_inc == EXP_MAX) begin
                        res_d   = {sign_q, EXP_MAX, {FRAC_W{1'b0}}};
                        ovf_d   = 1'b1;
                        vld_d   = 1'b1;
                        state_d = DONE;
                    end
                end else if (mant_q == '0) begin
                    res_d   = '0;
                    zero_d  = 1'b1;
                    vld_d   = 1'b1;
                    state_d = DONE;
                end else if (mant_q[FRAC_W]) begin
                    res_d   = {sign_q, exp_q, mant_q[FRAC_W-1:0]};
                    vld_d   = 1'b1;
                    state_d = DONE;
                end else if (exp_q == EXP_ONE) begin
                    res_d   = {sign_q, {EXP_W{1'b0}}, mant_q[FRAC_W-1:0]};
                    unf_d   = 1'b1;
                    vld_d   = 1'b1;
                    state_d = DONE;
                end else begin
                    mant_d = {mant_q[FRAC_W-1:0], 1'b0};
                    exp_d  = exp_q - EXP_ONE;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    vld_d   = 1'b0;
                    ovf_d   = 1'b0;
                    unf_d   = 1'b0;
                    zero_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; async reset abandons any operation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sign_q  <= 1'b0;
            exp_q   <= '0;
            mant_q  <= '0;
            carry_q <= 1'b0;
            res_q   <= '0;
            vld_q   <= 1'b0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
            zero_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sign_q  <= sign_d;
            exp_q   <= exp_d;
            mant_q  <= mant_d;
            carry_q <= carry_d;
            res_q   <= res_d;
            vld_q   <= vld_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
            zero_q  <= zero_d;
        end
    end
endmodule

// File: tb/tb_fp_add_normalizer.sv
// Randomised bench for fp_add_normalizer against a closed-form model
// (leading-one count, shift budget, latency formula).
module tb_fp_add_normalizer;
    logic clk;
    logic rst_n;
    int   n_chk;
    int   n_err;

    fp_add_normalizer_if #(.EXP_W(8), .FRAC_W(23)) bus ();

    fp_add_normalizer #(.EXP_W(8), .FRAC_W(23)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Closed-form model: result word, flags {ovf,unf,zero}, latency in edges.
    task automatic model(input logic s, input int e_in, input int m,
                         input logic c, output logic [31:0] res,
                         output logic [2:0] fl, output int lat);
        int e;
        int full;
        int lead;
        int need;
        e    = (e_in == 0) ? 1 : e_in;
        full = m;
        lat  = 1;
        fl   = 3'b000;
        if (e_in == 255) begin
            res = {s, 8'hFF, m[22:0]};
            return;
        end
        if (c) begin
            full = (full + (1 << 24)) / 2;
            e    = e + 1;
            lat  = lat + 1;
            if (e == 255) begin
                res = {s, 8'hFF, 23'd0};
                fl  = 3'b100;
                return;
            end
        end
        if (full == 0) begin
            res = 32'h0;
            fl  = 3'b001;
            lat = lat + 1;
            return;
        end
        lead = 0;
        for (int b = 0; b < 24; b++) if ((full >> b) & 1) lead = b;
        need = 23 - lead;
        if (need <= e - 1) begin
            full = full * (2 ** need);
            e    = e - need;
            lat  = lat + need + 1;
            res  = {s, e[7:0], full[22:0]};
        end else begin
            full = full * (2 ** (e - 1));
            lat  = lat + (e - 1) + 1;
            res  = {s, 8'h00, full[22:0]};
            fl   = 3'b010;
        end
    endtask

    task automatic run_op(input string tag, input logic s, input int e,
                          input int m, input logic c, input int hold);
        logic [31:0] er;
        logic [2:0]  ef;
        int          el;
        int          n;
        logic        busy_ok;
        logic [2:0]  fl;
        model(s, e, m, c, er, ef, el);
        chk({tag, ":in_ready"}, {31'd0, bus.in_ready}, 32'd1);
        bus.in_valid = 1'b1;
        bus.in_sign  = s;
        bus.in_exp   = e[7:0];
        bus.in_mant  = m[23:0];
        bus.in_carry = c;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        n = 1;
        busy_ok = 1'b1;
        while (!bus.out_valid && n < 40) begin
            if (bus.in_ready) busy_ok = 1'b0;
            @(posedge clk);
            #1;
            n++;
        end
        if (bus.in_ready) busy_ok = 1'b0;
        chk({tag, ":lat"}, n, el);
        chk({tag, ":busy"}, {31'd0, busy_ok}, 32'd1);
        if (n >= 40) begin
            chk({tag, ":timeout"}, 32'd1, 32'd0);
            return;
        end
        fl = {bus.out_overflow, bus.out_underflow, bus.out_zero};
        chk({tag, ":res"}, bus.out_result, er);
        chk({tag, ":flags"}, {29'd0, fl}, {29'd0, ef});
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            fl = {bus.out_overflow, bus.out_underflow, bus.out_zero};
            chk({tag, ":hold"}, {bus.out_valid, bus.in_ready, fl, 27'd0},
                {1'b1, 1'b0, ef, 27'd0});
            chk({tag, ":hold_res"}, bus.out_result, er);
        end
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        fl = {bus.out_overflow, bus.out_underflow, bus.out_zero};
        chk({tag, ":handoff"}, {bus.out_valid, bus.in_ready, fl, 27'd0},
            {1'b0, 1'b1, 3'b000, 27'd0});
    endtask

    initial begin
        logic seen_valid;
        int   e;
        int   m;
        int   sh;
        n_chk = 0;
        n_err = 0;
        rst_n = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_sign   = 1'b0;
        bus.in_exp    = '0;
        bus.in_mant   = '0;
        bus.in_carry  = 1'b0;
        bus.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_state", {bus.out_result},
            32'h0);
        chk("rst_ctl", {29'd0, bus.in_ready, bus.out_valid, bus.out_zero},
            {29'd0, 3'b100});
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        run_op("carry",   1'b0, 1,   32'h400000, 1'b1, 0);
        run_op("normal",  1'b1, 127, 32'h800000, 1'b0, 0);
        run_op("deep",    1'b0, 100, 32'h000001, 1'b0, 0);
        run_op("ovf",     1'b0, 254, 32'h800000, 1'b1, 0);
        run_op("zero",    1'b1, 50,  32'h000000, 1'b0, 0);
        run_op("subn",    1'b0, 3,   32'h100000, 1'b0, 0);
        run_op("pass",    1'b1, 255, 32'h412345, 1'b1, 0);
        run_op("exp0",    1'b0, 0,   32'h000123, 1'b0, 0);
        run_op("bkpr",    1'b1, 20,  32'h0F0000, 1'b0, 5);

        bus.in_valid = 1'b1;
        bus.in_sign  = 1'b0;
        bus.in_exp   = 8'd100;
        bus.in_mant  = 24'h000001;
        bus.in_carry = 1'b0;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_async", {bus.out_valid, bus.in_ready, 30'd0},
            {1'b0, 1'b1, 30'd0});
        chk("rst_async_res", bus.out_result, 32'h0);
        seen_valid = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
            if (bus.out_valid) seen_valid = 1'b1;
        end
        rst_n = 1'b1;
        repeat (30) begin
            @(posedge clk);
            #1;
            if (bus.out_valid) seen_valid = 1'b1;
        end
        chk("rst_no_pulse", {31'd0, seen_valid}, 32'd0);
        run_op("post_rst", 1'b1, 127, 32'h800000, 1'b0, 0);

        for (int k = 0; k < 150; k++) begin
            case ($urandom_range(0, 5))
                0:       e = 0;
                1:       e = 255;
                2:       e = $urandom_range(1, 6);
                3:       e = $urandom_range(250, 254);
                default: e = $urandom_range(1, 254);
            endcase
            sh = $urandom_range(0, 24);
            m  = ($urandom & 32'hFFFFFF) >> sh;
            run_op("rand", 1'($urandom), e, m, 1'($urandom_range(0, 3) == 0),
                   $urandom_range(0, 2));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
